// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Evaluates one dot product y = sum(a[i]*b[i]) over a shared single-port
// memory. Operands are fetched one pair at a time and accumulated in a wide
// signed accumulator. A single Q-format word is then written back, shifted
// right by FRAC_BITS and saturated to DATA_WIDTH.
module dsp_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 15
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] y_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] MAC  = 3'd3;
    localparam logic [2:0] WR_Y = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    // Largest and smallest DATA_WIDTH values, expressed at accumulator width
    // so the saturation compare is a plain signed comparison.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [2:0]                    state;
    logic [ADDR_WIDTH-1:0]         a_base_q;
    logic [ADDR_WIDTH-1:0]         b_base_q;
    logic [ADDR_WIDTH-1:0]         y_addr_q;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          idx;
    logic [LEN_WIDTH-1:0]          idx_inc;
    logic signed [DATA_WIDTH-1:0]  op_a;
    logic signed [DATA_WIDTH-1:0]  op_b;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]   product_ext;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]         sat_word;
    logic                          sat_flag;
    logic                          accept;
    logic                          last_term;

    // A transfer completes only on a cycle where the request is actually up.
    assign accept    = mem_req & mem_ack;
    assign idx_inc   = idx + LEN_WIDTH'(1);
    assign last_term = (idx_inc == len_q);

    // Full-precision product, sign-extended and added to the running sum.
    assign product     = op_a * op_b;
    assign product_ext = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    assign acc_sum     = acc + product_ext;
    assign shifted     = acc_sum >>> FRAC_BITS;

    // Clamp the shifted final sum into DATA_WIDTH and flag any clipping.
    always_comb begin
        sat_word = shifted[DATA_WIDTH-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_word = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_word = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Descriptor capture, operand registers, term index and accumulator.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            a_base_q <= '0;
            b_base_q <= '0;
            y_addr_q <= '0;
            len_q    <= '0;
            idx      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        y_addr_q <= y_addr;
                        len_q    <= length;
                        idx      <= '0;
                        acc      <= '0;
                    end
                end
                RD_A: begin
                    if (accept) begin
                        op_a <= mem_rdata;
                    end
                end
                RD_B: begin
                    if (accept) begin
                        op_b <= mem_rdata;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencer state and all registered memory/status outputs.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        mem_req  <= 1'b1;
                        if (length == '0) begin
                            state     <= WR_Y;
                            mem_we    <= 1'b1;
                            mem_addr  <= y_addr;
                            mem_wdata <= '0;
                        end else begin
                            state    <= RD_A;
                            mem_we   <= 1'b0;
                            mem_addr <= a_base;
                        end
                    end
                end
                RD_A: begin
                    if (accept) begin
                        state    <= RD_B;
                        mem_addr <= b_base_q + ADDR_WIDTH'(idx);
                    end
                end
                RD_B: begin
                    if (accept) begin
                        state   <= MAC;
                        mem_req <= 1'b0;
                    end
                end
                MAC: begin
                    mem_req <= 1'b1;
                    if (last_term) begin
                        state     <= WR_Y;
                        mem_we    <= 1'b1;
                        mem_addr  <= y_addr_q;
                        mem_wdata <= sat_word;
                        overflow  <= sat_flag;
                    end else begin
                        state    <= RD_A;
                        mem_we   <= 1'b0;
                        mem_addr <= a_base_q + ADDR_WIDTH'(idx_inc);
                    end
                end
                WR_Y: begin
                    if (accept) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
